add_check_mon: RTL and testbench
================================

# add_check_mon

Self-checking response monitor for the adder benches: the receiving end of the stimulus counter. It samples each applied operand pair and the DUT's sum/carry result a fixed number of cycles later, and compares the result against an internally computed reference. It counts passes and mismatches, latches the first failing vector and signals completion after a programmed number of vectors. It is synthesizable, so it serves both iverilog benches and on-board self-test.

## Interface
- WIDTH, 1: operand width (1 = half adder).
- LATENCY, 0: DUT cycles from operands applied to result valid; 0 = combinational DUT.
- NUM_VEC, 4: vectors to check before done.
- CNT_W, 16: width of pass/error counters.

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; pulse, sampled in IDLE/DONE only.
- in_valid  in  1  operands a/b applied to DUT this cycle.
- a  in  WIDTH  operand A as driven to DUT.
- b  in  WIDTH  operand B as driven to DUT.
- dut_o  in  WIDTH  DUT sum output.
- dut_c  in  1  DUT carry output.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- fail  out  1  err_cnt != 0.
- pass_cnt  out  CNT_W  matching compares.
- err_cnt  out  CNT_W  mismatching compares.
- first_a  out  WIDTH  operand A of first mismatch.
- first_b  out  WIDTH  operand B of first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE --start--> RUN. Entering RUN clears counters, first_a/first_b, issue and check counts, and the delay line.
- RUN: in_valid accepted only while issue_cnt < NUM_VEC; extra in_valid ignored. Accepted {a,b} enter a LATENCY-deep delay line with a valid bit.
- Compare on the delay-line output (LATENCY=0: same cycle as in_valid). Expected = a + b computed at WIDTH+1 bits; low WIDTH bits vs dut_o, MSB vs dut_c. Match increments pass_cnt, otherwise err_cnt.
- First mismatch of a run loads first_a/first_b. Later mismatches do not overwrite them.
- Counters saturate at all-ones and never wrap.
- RUN -> DONE in the cycle the NUM_VEC-th compare completes (check_cnt reaches NUM_VEC).
- DONE --start--> RUN (restart with clear). start while in RUN is ignored.
- If a compare and start coincide in DONE, start wins; no compare is pending in DONE.
- reset at any time, including mid-run, returns to IDLE and clears everything; in-flight vectors are discarded.

## Timing
- Reset values: busy=0, done=0, fail=0, pass_cnt=0, err_cnt=0, first_a=0, first_b=0.
- busy rises the cycle after start is sampled.
- A vector accepted at edge N is compared at edge N+LATENCY. Its counter update is visible after that edge.
- done rises on the same edge as the final counter update and holds until start or reset.
- fail follows err_cnt combinationally from registers; no extra latency.
- One compare per cycle maximum; back-to-back in_valid is fully supported.

## Configuration
- ADD_CHECK_STOP_ON_ERR_EN defined: the first mismatch forces RUN -> DONE on that same edge. Remaining in-flight vectors are discarded, so err_cnt = 1.
- Not defined: the run always checks all NUM_VEC vectors.

## Structure
- Package add_check_pkg holds the state enum (IDLE/RUN/DONE) and the default CNT_W constant.
- Sub-module add_check_dly is the parameterized LATENCY-stage delay line for {valid, a, b}. With LATENCY=0 it is a pass-through.
- Top holds the FSM, comparator, counters and first-error capture.

## Test plan
- WIDTH=1, LATENCY=0, correct half adder, 2-bit counter stimulus, start -> done after 4 vectors, pass_cnt=4, err_cnt=0, fail=0.
- Faulty DUT with carry stuck at 0 -> err_cnt=1 (vector a=1,b=1), pass_cnt=3, first_a=1, first_b=1, fail=1.
- LATENCY=2 registered DUT, 6 in_valid pulses with NUM_VEC=4 -> only 4 accepted, done rises 2 cycles after the 4th accept, pass_cnt=4.
- Reset asserted after 2 compares -> next edge all outputs 0, state IDLE; new start runs a clean 4/0 result.
- CNT_W=2, NUM_VEC=6, all pass -> pass_cnt saturates at 3.
- ADD_CHECK_STOP_ON_ERR_EN set, mismatch on vector 2 -> done on that edge, err_cnt=1, pass_cnt=1. Without the macro -> run completes with err_cnt=1, pass_cnt=3.

Source files
------------

// File: rtl/add_check_pkg.sv
// add_check_pkg: shared definitions for the adder response monitor.
//   state_t        - monitor FSM states (IDLE / RUN / DONE)
//   CNT_W_DEFAULT  - default width of the pass/error counters
package add_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/add_check_dly.sv
// add_check_dly: LATENCY-stage delay line for an accepted operand pair plus
// its valid bit, so the monitor compares against the DUT result that belongs
// to it. LATENCY = 0 makes this a pure pass-through.
// Ports:
//   clk       in   clock, posedge
//   reset     in   synchronous active-high reset
//   clear     in   synchronous flush (start of a new run)
//   in_valid  in   operand pair accepted this cycle
//   in_data   in   W  packed operands {a, b}
//   out_valid out  delayed valid
//   out_data  out  W  delayed operands
module add_check_dly #(
    parameter int W       = 2,
    parameter int LATENCY = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (LATENCY == 0) begin : g_pass
            // Combinational DUT: compare in the same cycle as in_valid.
            logic unused_ok;
            assign unused_ok = ^{clk, reset, clear};
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
                logic [W:0] q_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (reset || clear) q_reg <= '0;
                        else                q_reg <= {in_valid, in_data};
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (reset || clear) q_reg <= '0;
                        else                q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
            assign {out_valid, out_data} = g_stage[LATENCY-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/add_check_mon.sv
// add_check_mon: self-checking response monitor for adder benches.
// Samples each accepted operand pair, delays it LATENCY cycles, and compares
// the DUT's {carry, sum} against a + b. Counts passes and mismatches
// (saturating), captures the operands of the first mismatch and reports done
// after NUM_VEC compares.
// Optional build macro: ADD_CHECK_STOP_ON_ERR_EN - when defined, the first
// mismatch ends the run immediately and in-flight vectors are discarded.
// Ports:
//   clk, reset        clock / synchronous active-high reset
//   start             begin a run (honoured in IDLE and DONE only)
//   in_valid, a, b    operands applied to the DUT this cycle
//   dut_o, dut_c      DUT sum and carry outputs
//   busy, done, fail  status (RUN, DONE, err_cnt != 0)
//   pass_cnt, err_cnt compare counters, CNT_W bits, saturating
//   first_a, first_b  operands of the first mismatch of the run
module add_check_mon
    import add_check_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0,
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] dut_o,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b
);

    localparam int               IW        = $clog2(NUM_VEC + 1);
    localparam logic [IW-1:0]    NUM_VEC_C = IW'(NUM_VEC);

    state_t             state_reg, state_next;
    logic [IW-1:0]      issue_cnt_reg, check_cnt_reg;
    logic [CNT_W-1:0]   pass_cnt_reg, err_cnt_reg;
    logic [WIDTH-1:0]   first_a_reg, first_b_reg;

    logic               clear;
    logic               accept;
    logic               dly_valid;
    logic [WIDTH-1:0]   cmp_a, cmp_b;
    logic               cmp_valid;
    logic [WIDTH:0]     expected;
    logic               mismatch;
    logic               last_check;

    // Vectors beyond NUM_VEC in a run are silently dropped.
    assign accept = (state_reg == RUN) && in_valid && (issue_cnt_reg < NUM_VEC_C);

    add_check_dly #(
        .W       (2 * WIDTH),
        .LATENCY (LATENCY)
    ) u_dly (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (accept),
        .in_data   ({a, b}),
        .out_valid (dly_valid),
        .out_data  ({cmp_a, cmp_b})
    );

    // Outside RUN nothing is compared, so a start in DONE always wins.
    assign cmp_valid  = dly_valid && (state_reg == RUN);
    assign expected   = {1'b0, cmp_a} + {1'b0, cmp_b};
    assign mismatch   = cmp_valid && ({dut_c, dut_o} != expected);
    assign last_check = cmp_valid && ((check_cnt_reg + IW'(1)) == NUM_VEC_C);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (last_check) begin
                    state_next = DONE;
                end
`ifdef ADD_CHECK_STOP_ON_ERR_EN
                else if (mismatch) begin
                    state_next = DONE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            issue_cnt_reg <= '0;
            check_cnt_reg <= '0;
            pass_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            first_a_reg   <= '0;
            first_b_reg   <= '0;
        end else begin
            if (accept)    issue_cnt_reg <= issue_cnt_reg + IW'(1);
            if (cmp_valid) check_cnt_reg <= check_cnt_reg + IW'(1);
            if (cmp_valid && !mismatch && (pass_cnt_reg != '1))
                pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
            if (mismatch) begin
                if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                // err_cnt saturates rather than wraps, so zero means
                // "no mismatch yet in this run".
                if (err_cnt_reg == '0) begin
                    first_a_reg <= cmp_a;
                    first_b_reg <= cmp_b;
                end
            end
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign fail     = (err_cnt_reg != '0);
    assign pass_cnt = pass_cnt_reg;
    assign err_cnt  = err_cnt_reg;
    assign first_a  = first_a_reg;
    assign first_b  = first_b_reg;

endmodule

// File: tb/tb_add_check_mon.sv
// tb_add_check_mon: directed bench for add_check_mon.
//   u0: WIDTH=1, LATENCY=0, NUM_VEC=4 half adder with carry-stuck and
//       sum-corrupt fault controls.
//   u1: WIDTH=2, LATENCY=2 registered adder, NUM_VEC=4, extra in_valid pulses.
//   u2: WIDTH=1, CNT_W=2, NUM_VEC=6 to exercise counter saturation.
// Expected values follow ADD_CHECK_STOP_ON_ERR_EN when it is defined.
module tb_add_check_mon;

`ifdef ADD_CHECK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- u0: combinational half adder ----------------
    logic        start0, iv0, a0, b0, fault_c0, corrupt0;
    logic [1:0]  s0;
    logic        o0, c0;
    logic        busy0, done0, fail0, fa0, fb0;
    logic [15:0] pass0, err0;
    assign s0 = {1'b0, a0} + {1'b0, b0};
    assign o0 = s0[0] ^ corrupt0;
    assign c0 = fault_c0 ? 1'b0 : s0[1];

    add_check_mon #(.WIDTH(1), .LATENCY(0), .NUM_VEC(4), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .start(start0), .in_valid(iv0), .a(a0), .b(b0),
        .dut_o(o0), .dut_c(c0), .busy(busy0), .done(done0), .fail(fail0),
        .pass_cnt(pass0), .err_cnt(err0), .first_a(fa0), .first_b(fb0));

    // ---------------- u1: 2-bit adder, two register stages ----------------
    logic        start1, iv1, fault1;
    logic [1:0]  a1, b1;
    logic [2:0]  r1a, r1b;
    logic        busy1, done1, fail1;
    logic [15:0] pass1, err1;
    logic [1:0]  fa1, fb1;
    always_ff @(posedge clk) begin
        r1a <= ({1'b0, a1} + {1'b0, b1}) ^ (fault1 ? 3'b100 : 3'b000);
        r1b <= r1a;
    end

    add_check_mon #(.WIDTH(2), .LATENCY(2), .NUM_VEC(4), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(iv1), .a(a1), .b(b1),
        .dut_o(r1b[1:0]), .dut_c(r1b[2]), .busy(busy1), .done(done1), .fail(fail1),
        .pass_cnt(pass1), .err_cnt(err1), .first_a(fa1), .first_b(fb1));

    // ---------------- u2: saturation, CNT_W=2 ----------------
    logic        start2, iv2, a2, b2;
    logic [1:0]  s2;
    logic        busy2, done2, fail2, fa2, fb2;
    logic [1:0]  pass2, err2;
    assign s2 = {1'b0, a2} + {1'b0, b2};

    add_check_mon #(.WIDTH(1), .LATENCY(0), .NUM_VEC(6), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(iv2), .a(a2), .b(b2),
        .dut_o(s2[0]), .dut_c(s2[1]), .busy(busy2), .done(done2), .fail(fail2),
        .pass_cnt(pass2), .err_cnt(err2), .first_a(fa2), .first_b(fb2));

    task automatic start_u0();
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("u0_busy_after_start", busy0, 1);
    endtask

    // 2-bit counter stimulus {a,b} = 0..3; corrupt_idx selects a corrupted sum
    task automatic run_u0(input string nm, input int corrupt_idx, input int done_from);
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            a0 = v[1]; b0 = v[0]; iv0 = 1'b1; corrupt0 = (i == corrupt_idx);
            tick();
            chk({nm, "_done"}, done0, (i >= done_from) ? 1 : 0);
        end
        iv0 = 1'b0; corrupt0 = 1'b0;
    endtask

    logic [1:0] va1 [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
    logic [1:0] vb1 [6] = '{2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1};

    task automatic run_u1(input string nm, input int fault_idx, input int done_from);
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk({nm, "_busy"}, busy1, 1);
        for (int j = 0; j < 6; j++) begin
            a1 = va1[j]; b1 = vb1[j]; iv1 = 1'b1; fault1 = (j == fault_idx);
            tick();
            chk({nm, "_done"}, done1, (j >= done_from) ? 1 : 0);
        end
        iv1 = 1'b0; fault1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start0 = 0; iv0 = 0; a0 = 0; b0 = 0; fault_c0 = 0; corrupt0 = 0;
        start1 = 0; iv1 = 0; a1 = 0; b1 = 0; fault1 = 0;
        start2 = 0; iv2 = 0; a2 = 0; b2 = 0;
        repeat (2) tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_fail", fail0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_first_a", fa0, 0);
        chk("rst_first_b", fb0, 0);
        reset = 1'b0;
        tick();

        // A: correct half adder, 4/0
        start_u0();
        run_u0("A", -1, 3);
        chk("A_pass", pass0, 4);
        chk("A_err", err0, 0);
        chk("A_fail", fail0, 0);
        chk("A_busy", busy0, 0);

        // B: carry stuck at 0 -> only (1,1) fails, and it is the last vector
        fault_c0 = 1'b1;
        start_u0();
        run_u0("B", -1, 3);
        fault_c0 = 1'b0;
        chk("B_pass", pass0, 3);
        chk("B_err", err0, 1);
        chk("B_first_a", fa0, 1);
        chk("B_first_b", fb0, 1);
        chk("B_fail", fail0, 1);

        // C: sum corrupted on the second vector (a=0,b=1)
        start_u0();
        run_u0("C", 1, STOP ? 1 : 3);
        chk("C_pass", pass0, STOP ? 1 : 3);
        chk("C_err", err0, 1);
        chk("C_first_a", fa0, 0);
        chk("C_first_b", fb0, 1);

        // D: reset after two compares, then a clean run
        fault_c0 = 1'b1;
        start_u0();
        a0 = 1; b0 = 1; iv0 = 1; tick();
        a0 = 0; b0 = 0; tick();
        iv0 = 0; fault_c0 = 1'b0;
        chk("D_pass_mid", pass0, STOP ? 0 : 1);
        chk("D_err_mid", err0, 1);
        chk("D_first_a_mid", fa0, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("D_rst_busy", busy0, 0);
        chk("D_rst_done", done0, 0);
        chk("D_rst_fail", fail0, 0);
        chk("D_rst_pass", pass0, 0);
        chk("D_rst_err", err0, 0);
        chk("D_rst_first_a", fa0, 0);
        chk("D_rst_first_b", fb0, 0);
        a0 = 1; b0 = 0; iv0 = 1; tick(); iv0 = 0;
        chk("D_idle_ignores_valid", pass0, 0);
        start_u0();
        run_u0("D2", -1, 3);
        chk("D2_pass", pass0, 4);
        chk("D2_err", err0, 0);

        // E: LATENCY=2, 6 pulses, only 4 accepted, done 2 edges after 4th accept
        run_u1("E", -1, 5);
        chk("E_pass", pass1, 4);
        chk("E_err", err1, 0);
        // F: result of third vector (1,3) corrupted in the DUT pipeline
        run_u1("F", 2, STOP ? 4 : 5);
        chk("F_pass", pass1, STOP ? 2 : 3);
        chk("F_err", err1, 1);
        chk("F_first_a", fa1, 1);
        chk("F_first_b", fb1, 3);
        chk("F_fail", fail1, 1);

        // G: CNT_W=2, six passing vectors -> pass_cnt sticks at 3
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("G_busy", busy2, 1);
        for (int j = 0; j < 6; j++) begin
            a2 = j[0]; b2 = j[1]; iv2 = 1'b1;
            tick();
            chk("G_pass", pass2, (j + 1 > 3) ? 3 : j + 1);
        end
        iv2 = 1'b0;
        chk("G_done", done2, 1);
        chk("G_err", err2, 0);
        chk("G_fail", fail2, 0);
        chk("G_first", {fa2, fb2}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
